// File: rtl/counter_pkg.sv
// Shared types and helpers for updown_mod_counter and its prescaler.
package counter_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_MOD      = 256;
    localparam int unsigned DEF_PRESCALE = 4;

    typedef enum logic [0:0] {
        COUNT_ST,
        DONE_ST
    } state_e;

    // Out-of-range load values saturate at the top of the count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [31:0] modv);
        return (value < modv) ? value : (modv - 32'd1);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks every PRESCALE-th enabled cycle.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    assign tick = en & (pcnt_q == LAST);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with load, clear, terminal-count strobe and one-shot halt.
// Optional prescaler on the step input when COUNTER_PRESCALE_EN is defined.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MOD      = DEF_MOD,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

    if (WIDTH < 2 || WIDTH > 32 || MOD < 2 || 64'(MOD) > (64'd1 << WIDTH) || PRESCALE < 2)
    begin : g_param_check
        $error("updown_mod_counter: illegal WIDTH/MOD/PRESCALE combination");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             step;
    logic             at_term;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr | ld),
        .en    (en),
        .tick  (step)
    );
`else
    assign step = en;
`endif

    assign at_term = up ? (cnt_q == MAX) : (cnt_q == '0);
    // rst_n gating keeps the strobe quiet while reset is held.
    assign tc      = rst_n & step & (state_q == COUNT_ST) & at_term;
    assign done    = (state_q == DONE_ST);
    assign Q       = cnt_q;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (clr) begin
            cnt_d   = '0;
            state_d = COUNT_ST;
        end else if (ld) begin
            cnt_d   = WIDTH'(clamp_load(32'(data), 32'(MOD)));
            state_d = COUNT_ST;
        end else if (step && state_q == COUNT_ST) begin
            if (at_term) begin
                if (oneshot) begin
                    state_d = DONE_ST;
                end else begin
                    cnt_d = up ? '0 : MAX;
                end
            end else begin
                cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= COUNT_ST;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=8, MOD=10); follows COUNTER_PRESCALE_EN if set.
module tb_updown_mod_counter;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MOD      = 10;
    localparam int unsigned PRESCALE = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             ld = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             en = 1'b0;
    logic             up = 1'b1;
    logic             oneshot = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             done;

    updown_mod_counter #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .ld      (ld),
        .data    (data),
        .en      (en),
        .up      (up),
        .oneshot (oneshot),
        .Q       (Q),
        .tc      (tc),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int dn;
        int t;
    } exp_t;

    exp_t sb[$];

    // Reference model: count value, halted flag, enabled-cycle count within a prescale period.
    int m_q    = 0;
    bit m_halt = 1'b0;
    int m_pc   = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // One clock of stimulus: drive at negedge, record expected outputs, advance model.
    task automatic cyc(input bit c, input bit l, input int d, input bit e,
                       input bit u, input bit o);
        bit   step;
        bit   term;
        exp_t x;
        @(negedge clk);
        clr = c; ld = l; data = WIDTH'(d); en = e; up = u; oneshot = o;
`ifdef COUNTER_PRESCALE_EN
        step = e && (m_pc == PRESCALE - 1);
`else
        step = e;
`endif
        term = u ? (m_q == MOD - 1) : (m_q == 0);
        x.q  = m_q;
        x.dn = int'(m_halt);
        x.t  = int'(step && !m_halt && term);
        sb.push_back(x);
        if (c) begin
            m_q = 0; m_halt = 1'b0; m_pc = 0;
        end else if (l) begin
            m_q = (d < MOD) ? d : MOD - 1;
            m_halt = 1'b0; m_pc = 0;
        end else begin
            if (e) m_pc = (m_pc + 1) % PRESCALE;
            if (step && !m_halt) begin
                if (term && o) m_halt = 1'b1;
                else m_q = (m_q + (u ? 1 : MOD - 1)) % MOD;
            end
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("Q", int'(Q), x.q);
                check("done", int'(done), x.dn);
                check("tc", int'(tc), x.t);
            end
        end
    end

    initial begin : driver
        bit u;
        bit o;
        // Reset state, with en high and down-direction so tc would fire if not gated.
        en = 1'b1; up = 1'b0;
        #13;
        check("reset_Q", int'(Q), 0);
        check("reset_done", int'(done), 0);
        check("reset_tc", int'(tc), 0);
        @(negedge clk);
        en = 1'b0; up = 1'b1;
        rst_n = 1'b1;

        // Wrap up from 7.
        cyc(0, 1, 7, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 1, 1, 0);
        // One-shot down from 2, then reload.
        cyc(0, 1, 2, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 1, 5, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // Clamp and priority.
        cyc(0, 1, 200, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 1, 3, 1, 1, 0);
        cyc(0, 1, 3, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        // Direction flip at the boundary.
        cyc(0, 1, 0, 0, 0, 0);
        repeat (PRESCALE) cyc(0, 0, 0, 1, 0, 0);
        repeat (PRESCALE) cyc(0, 0, 0, 1, 1, 0);
        // Prescaler-style gaps: en pulses separated by idle cycles.
        cyc(1, 0, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 1, 0);

        // Async reset while halted.
        cyc(0, 1, 1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_Q", int'(Q), 0);
        check("async_done", int'(done), 0);
        m_q = 0; m_halt = 1'b0; m_pc = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        u = 1'b1;
        o = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) u = ~u;
            if ($urandom_range(0, 15) == 0) o = ~o;
            cyc($urandom_range(0, 23) == 0, $urandom_range(0, 11) == 0,
                int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, u, o);
        end

        @(negedge clk);
        #5;
        if (sb.size() != 0) check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
